// File: rtl/uart_tx_framed.sv
// UART transmitter: configurable data bits, parity, stop bits and line break.
// Frame settings are captured on each accepted payload; outputs are decoded from the current state.
module uart_tx_framed #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      txd,
  output logic                      busy,
  output logic                      tx_done,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [3:0]                data_bits,
  input  logic [1:0]                parity_mode,
  input  logic                      stop_bits,
  input  logic                      break_req
);

  localparam int CW = PRESCALE_WIDTH + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [3:0]                nbits_q, nbits_d;
  logic [1:0]                pmode_q, pmode_d;
  logic                      stop2_q, stop2_d;
  logic                      par_q, par_d;
  logic                      brk_q, brk_d;

  logic [PRESCALE_WIDTH-1:0] pre_eff;
  logic [CW-1:0]             bit_last;
  logic                      bit_end;
  logic [3:0]                nbits_in;
  logic                      done_c;
  logic                      txd_c;

  assign pre_eff  = (pre_q == '0) ? PRESCALE_WIDTH'(1) : pre_q;
  assign bit_last = {pre_eff, 3'b000} - CW'(1);
  assign bit_end  = (cnt_q == bit_last);

  always_comb begin
    if (data_bits < 4'd5)                    nbits_in = 4'd5;
    else if (data_bits > 4'(DATA_WIDTH))     nbits_in = 4'(DATA_WIDTH);
    else                                     nbits_in = data_bits;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pre_d   = pre_q;
    nbits_d = nbits_q;
    pmode_d = pmode_q;
    stop2_d = stop2_q;
    par_d   = par_q;
    brk_d   = brk_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (break_req) begin
          state_d = S_BREAK;
          pre_d   = prescale;
          brk_d   = 1'b1;
        end else if (s_axis_tvalid) begin
          state_d = S_START;
          data_d  = s_axis_tdata;
          pre_d   = prescale;
          nbits_d = nbits_in;
          pmode_d = parity_mode;
          stop2_d = stop_bits;
          par_d   = 1'b0;
          brk_d   = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d  = '0;
          data_d = data_q >> 1;
          par_d  = par_q ^ data_q[0];
          bit_d  = bit_q + 4'd1;
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = (pmode_q != 2'b00) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d = '0;
          // A break recovery always uses a single stop period and reports no completion.
          if (brk_q || !stop2_q || bit_q == 4'd1) begin
            state_d = S_IDLE;
            done_c  = !brk_q;
          end else begin
            bit_d = 4'd1;
          end
        end
      end
      S_BREAK: begin
        // Counter saturates at the end of the first period so release can come any time after.
        if (!bit_end) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!break_req) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_c = 1'b1;
    case (state_q)
      S_START, S_BREAK: txd_c = 1'b0;
      S_DATA:           txd_c = data_q[0];
      S_PARITY: begin
        case (pmode_q)
          2'b01:   txd_c = par_q;
          2'b10:   txd_c = ~par_q;
          default: txd_c = 1'b1;
        endcase
      end
      default: txd_c = 1'b1;
    endcase
  end

  assign s_axis_tready = !rst && (state_q == S_IDLE) && !break_req;
  assign busy          = !rst && (state_q != S_IDLE);
  assign tx_done       = !rst && done_c;
  assign txd           = rst | txd_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      pre_q   <= '0;
      nbits_q <= 4'd5;
      pmode_q <= '0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pre_q   <= pre_d;
      nbits_q <= nbits_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: expected line waveform built per frame from the framing rules.
module tb_uart_tx_framed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        txd;
  logic        busy;
  logic        tx_done;
  logic [15:0] prescale = 16'd1;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;
  logic        break_req = 1'b0;

  int  tests = 0;
  int  fails = 0;
  time last_xfer = 0;
  int  prev_len = 0;
  bit  prev_frame = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .txd(txd), .busy(busy), .tx_done(tx_done),
    .prescale(prescale), .data_bits(data_bits), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .break_req(break_req)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Starts at a falling edge with the DUT idle; ends at the falling edge of the following idle cycle.
  task automatic do_frame(input logic [7:0] d, input logic [15:0] ps, input logic [3:0] db,
                          input logic [1:0] pm, input logic sb, input bit hold, input bit brk_mid);
    int   per, n, len;
    logic p, last;
    time  t0;
    logic bits[$];
    per = ((ps == 16'd0) ? 1 : int'(ps)) * 8;
    if (db < 4'd5) n = 5;
    else if (db > 4'd8) n = 8;
    else n = int'(db);
    bits = {};
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == 2'b01) bits.push_back(p);
    else if (pm == 2'b10) bits.push_back(~p);
    else if (pm == 2'b11) bits.push_back(1'b1);
    bits.push_back(1'b1);
    if (sb) bits.push_back(1'b1);
    len = bits.size() * per;

    s_axis_tdata = d; prescale = ps; data_bits = db; parity_mode = pm; stop_bits = sb;
    s_axis_tvalid = 1'b1;
    #1;
    check1("tready_before_xfer", s_axis_tready, 1'b1);
    @(posedge clk);
    t0 = $time;
    if (prev_frame) checkn("xfer_interval", int'((t0 - last_xfer) / 10), prev_len + 1);
    @(negedge clk);
    // Scramble every frame input: the frame in flight must not notice.
    s_axis_tdata = 8'($urandom);
    prescale     = 16'($urandom_range(0, 3));
    data_bits    = 4'($urandom);
    parity_mode  = 2'($urandom);
    stop_bits    = 1'($urandom);
    s_axis_tvalid = hold;
    if (brk_mid) break_req = 1'b1;
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < per; c++) begin
        last = (k == bits.size() - 1) && (c == per - 1);
        check1("frame_txd", txd, bits[k]);
        check1("frame_busy", busy, 1'b1);
        check1("frame_tx_done", tx_done, last);
        check1("frame_tready", s_axis_tready, 1'b0);
        if (last) break_req = 1'b0;
        @(negedge clk);
      end
    end
    check1("after_txd", txd, 1'b1);
    check1("after_busy", busy, 1'b0);
    check1("after_tx_done", tx_done, 1'b0);
    check1("after_tready", s_axis_tready, 1'b1);
    last_xfer  = t0;
    prev_len   = len;
    prev_frame = 1;
  endtask

  // break_req high for h cycles starting in an idle cycle: low for max(period, h), then one high period.
  task automatic do_break(input logic [15:0] ps, input int h);
    int per, low;
    per = ((ps == 16'd0) ? 1 : int'(ps)) * 8;
    low = (h > per) ? h : per;
    prescale = ps; break_req = 1'b1; s_axis_tvalid = 1'b1;
    #1;
    check1("brk_req_tready", s_axis_tready, 1'b0);
    check1("brk_req_busy", busy, 1'b0);
    for (int i = 1; i <= low + per; i++) begin
      @(negedge clk);
      break_req = (i < h);
      prescale  = 16'($urandom_range(0, 7));
      check1("brk_txd", txd, (i <= low) ? 1'b0 : 1'b1);
      check1("brk_busy", busy, 1'b1);
      check1("brk_tx_done", tx_done, 1'b0);
      check1("brk_tready", s_axis_tready, 1'b0);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check1("brk_end_txd", txd, 1'b1);
    check1("brk_end_busy", busy, 1'b0);
    check1("brk_end_tready", s_axis_tready, 1'b1);
    prev_frame = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_txd", txd, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tready", s_axis_tready, 1'b0);
    check1("rst_tx_done", tx_done, 1'b0);
    rst = 1'b0;
    #1;
    check1("post_rst_tready", s_axis_tready, 1'b1);

    // Directed frames
    do_frame(8'h55, 16'd1, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
    do_frame(8'h07, 16'd1, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0);
    do_frame(8'h07, 16'd1, 4'd8, 2'b10, 1'b0, 1'b0, 1'b0);
    do_frame(8'hFF, 16'd1, 4'd5, 2'b00, 1'b1, 1'b1, 1'b0);
    do_frame(8'hFF, 16'd1, 4'd5, 2'b00, 1'b1, 1'b1, 1'b0);
    do_frame(8'hA3, 16'd0, 4'd8, 2'b11, 1'b0, 1'b0, 1'b0);
    do_frame(8'hC6, 16'd1, 4'd0, 2'b01, 1'b0, 1'b0, 1'b1);
    do_frame(8'h3C, 16'd2, 4'd15, 2'b10, 1'b1, 1'b0, 1'b0);

    // Line break, short and long request
    do_break(16'd2, 3);
    do_break(16'd1, 20);

    // Reset in the middle of the data bits
    s_axis_tdata = 8'h0F; prescale = 16'd1; data_bits = 4'd8; parity_mode = 2'b00;
    stop_bits = 1'b0; s_axis_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (8 * 3) @(negedge clk);
    check1("mid_data_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check1("abort_txd", txd, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_tready", s_axis_tready, 1'b0);
    check1("abort_tx_done", tx_done, 1'b0);
    rst = 1'b0;
    #1;
    check1("abort_release_tready", s_axis_tready, 1'b1);
    prev_frame = 0;
    @(negedge clk);
    do_frame(8'h81, 16'd1, 4'd8, 2'b01, 1'b1, 1'b0, 1'b0);

    // Randomized frames, back-to-back
    for (int r = 0; r < 16; r++) begin
      do_frame(8'($urandom), 16'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
